// File: rtl/noc_packet_injector.sv
// noc_packet_injector
//   Feeds the injection port of router (0,0). On start it reads three filter
//   rows and five ifmap rows from a synchronous scratchpad and turns each
//   24-bit word into 39-bit mesh packets for the 3x3 PE array (x=0..2, y=1..3).
//   Filter row r goes to every PE of mesh row y=r+1. Ifmap row k goes along the
//   diagonal x+y-1==k, with x ascending.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 one-cycle pulse, accepted only in IDLE
//   busy / done           transfer in progress / one-cycle completion pulse
//   mem_rd_en, mem_addr   scratchpad read strobe and address
//   mem_rdata             read data, valid one cycle after mem_rd_en
//   pkt_data, pkt_valid   packet towards the injection bridge
//   pkt_ready             bridge accepts when valid && ready at the clock edge
module noc_packet_injector #(
  parameter int ADDR_W    = 10,
  parameter int ROW_WORDS = 2,
  parameter int FILT_BASE = 0,
  parameter int IFM_BASE  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [23:0]       mem_rdata,
  output logic [38:0]       pkt_data,
  output logic              pkt_valid,
  input  logic              pkt_ready
);

  // The word index field is 3 bits wide.
  if (ROW_WORDS < 1 || ROW_WORDS > 8) begin : g_bad_row_words
    $error("noc_packet_injector: ROW_WORDS must be in 1..8");
  end

  typedef struct packed {
    logic [3:0]  dst_x;
    logic [3:0]  dst_y;
    logic        typ;      // 0 filter, 1 ifmap
    logic [2:0]  row;
    logic [2:0]  word;
    logic [23:0] payload;
  } pkt_t;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] F_RD   = 3'd1;
  localparam logic [2:0] F_WAIT = 3'd2;
  localparam logic [2:0] F_SEND = 3'd3;
  localparam logic [2:0] I_RD   = 3'd4;
  localparam logic [2:0] I_WAIT = 3'd5;
  localparam logic [2:0] I_SEND = 3'd6;
  localparam logic [2:0] DONE   = 3'd7;

  localparam logic [2:0]        LAST_W = 3'(ROW_WORDS - 1);
  localparam logic [ADDR_W-1:0] RW_A   = ADDR_W'(ROW_WORDS);
  localparam logic [ADDR_W-1:0] FB_A   = ADDR_W'(FILT_BASE);
  localparam logic [ADDR_W-1:0] IB_A   = ADDR_W'(IFM_BASE);

  logic [2:0]  state;
  logic [2:0]  row;       // filter r or ifmap k
  logic [2:0]  word;
  logic [1:0]  dst;       // destination ordinal within the current word
  logic [23:0] payload;   // word held while its packets drain

  logic        is_ifm;
  logic [1:0]  last_dst;
  logic        last_row;
  logic [2:0]  rd_state;

  // Address arithmetic wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] rd_addr(input logic ifm, input logic [2:0] r,
                                                input logic [2:0] w);
    return (ifm ? IB_A : FB_A) + ADDR_W'(r) * RW_A + ADDR_W'(w);
  endfunction

  // Filter: x = d, y = r+1. Ifmap: the diagonal starts at x = max(k-2, 0).
  function automatic pkt_t mk_pkt(input logic ifm, input logic [2:0] r, input logic [2:0] w,
                                  input logic [1:0] d, input logic [23:0] p);
    logic [3:0] x;
    logic [3:0] y;
    x = 4'(d);
    if (ifm && r > 3'd2) x = 4'(r - 3'd2) + 4'(d);
    y = ifm ? (4'(r) + 4'd1 - x) : (4'(r) + 4'd1);
    return {x, y, ifm, r, w, p};
  endfunction

  always_comb begin
    is_ifm   = (state == I_RD) || (state == I_WAIT) || (state == I_SEND);
    rd_state = is_ifm ? I_RD : F_RD;
    last_row = is_ifm ? (row == 3'd4) : (row == 3'd2);
    // Diagonal lengths are 1,2,3,2,1 for k = 0..4.
    if (!is_ifm)          last_dst = 2'd2;
    else if (row <= 3'd2) last_dst = row[1:0];
    else                  last_dst = 2'(3'd4 - row);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      pkt_data  <= '0;
      pkt_valid <= 1'b0;
      row       <= '0;
      word      <= '0;
      dst       <= '0;
      payload   <= '0;
    end else begin
      done      <= 1'b0;
      mem_rd_en <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state     <= F_RD;
          busy      <= 1'b1;
          row       <= '0;
          word      <= '0;
          dst       <= '0;
          mem_rd_en <= 1'b1;
          mem_addr  <= rd_addr(1'b0, 3'd0, 3'd0);
        end
        F_RD, I_RD: state <= is_ifm ? I_WAIT : F_WAIT;
        F_WAIT, I_WAIT: begin
          payload   <= mem_rdata;
          pkt_data  <= mk_pkt(is_ifm, row, word, 2'd0, mem_rdata);
          pkt_valid <= 1'b1;
          dst       <= '0;
          state     <= is_ifm ? I_SEND : F_SEND;
        end
        F_SEND, I_SEND: if (pkt_ready) begin
          if (dst != last_dst) begin
            // Next destination goes out the following cycle, no bubble.
            dst      <= dst + 2'd1;
            pkt_data <= mk_pkt(is_ifm, row, word, dst + 2'd1, payload);
          end else begin
            pkt_valid <= 1'b0;
            if (word != LAST_W) begin
              word      <= word + 3'd1;
              mem_rd_en <= 1'b1;
              mem_addr  <= rd_addr(is_ifm, row, word + 3'd1);
              state     <= rd_state;
            end else if (!last_row) begin
              word      <= '0;
              row       <= row + 3'd1;
              mem_rd_en <= 1'b1;
              mem_addr  <= rd_addr(is_ifm, row + 3'd1, 3'd0);
              state     <= rd_state;
            end else if (!is_ifm) begin
              word      <= '0;
              row       <= '0;
              mem_rd_en <= 1'b1;
              mem_addr  <= rd_addr(1'b1, 3'd0, 3'd0);
              state     <= I_RD;
            end else begin
              word  <= '0;
              row   <= '0;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_packet_injector.sv
// tb_noc_packet_injector
//   Drives noc_packet_injector from a table of run configurations, with
//   randomized pkt_ready backpressure and random scratchpad contents, and
//   compares every read address and accepted packet against a reference
//   sequence enumerated directly from the row/diagonal routing rules.
//   Hand-written sequences cover the reset state, fixed packet values,
//   diagonal destinations and a reset that aborts a stalled transfer.
module tb_noc_packet_injector;
  localparam int AW   = 10;
  localparam int RW   = 2;
  localparam int FB   = 0;
  localparam int IB   = 16;
  localparam int NPKT = 18 * RW;
  localparam int NRD  = 8 * RW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, mem_rd_en, pkt_valid;
  logic [AW-1:0] mem_addr;
  logic [23:0]   mem_rdata = '0;
  logic [38:0]   pkt_data;
  logic          pkt_ready = 1'b0;

  always #5 clk = ~clk;

  noc_packet_injector #(.ADDR_W(AW), .ROW_WORDS(RW), .FILT_BASE(FB), .IFM_BASE(IB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .pkt_data(pkt_data), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready)
  );

  // Scratchpad: contents are a + 0x100 + salt.
  logic [23:0] salt = '0;
  function automatic logic [23:0] memval(input logic [AW-1:0] a);
    return 24'(a) + 24'h100 + salt;
  endfunction
  always @(posedge clk) if (mem_rd_en) mem_rdata <= memval(mem_addr);

  int checks = 0;
  int errors = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: enumerate packets from the routing rules.
  logic [38:0]   exp_pkt[$];
  logic [AW-1:0] exp_addr[$];
  logic [38:0]   got[$];

  function automatic logic [38:0] mk(input int x, input int y, input int t, input int r,
                                     input int w, input logic [23:0] p);
    return {4'(x), 4'(y), 1'(t), 3'(r), 3'(w), p};
  endfunction

  task automatic build_model();
    logic [AW-1:0] a;
    exp_pkt.delete();
    exp_addr.delete();
    for (int r = 0; r < 3; r++)
      for (int w = 0; w < RW; w++) begin
        a = AW'(FB + r * RW + w);
        exp_addr.push_back(a);
        for (int x = 0; x < 3; x++) exp_pkt.push_back(mk(x, r + 1, 0, r, w, memval(a)));
      end
    for (int k = 0; k < 5; k++)
      for (int w = 0; w < RW; w++) begin
        a = AW'(IB + k * RW + w);
        exp_addr.push_back(a);
        for (int x = 0; x < 3; x++)
          for (int y = 1; y <= 3; y++)
            if (x + y - 1 == k) exp_pkt.push_back(mk(x, y, 1, k, w, memval(a)));
      end
  endtask

  typedef struct {
    int          mode;      // 0 ready always high, 1 random with long lows
    int          start_at;  // packet index at which a stray start is pulsed, -1 none
    int          abort_at;  // packet index whose stall gets reset, -1 none
    logic [23:0] s;
    int          exp_pkts;
    int          exp_rds;
    int          exp_done;
  } vec_t;

  task automatic run(input vec_t v);
    int idx, rd, dn, cyc, low, post, sc;
    bit stall, fin, sdone;
    logic [38:0] held;
    idx = 0; rd = 0; dn = 0; cyc = 0; low = 0; post = 0; sc = 0;
    stall = 0; fin = 0; sdone = 0; held = '0;
    salt = v.s;
    build_model();
    got.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (!fin) begin
      // observe
      if (mem_rd_en) begin
        if (rd < exp_addr.size()) chk("rd_addr", 64'(mem_addr), 64'(exp_addr[rd]));
        else chk("extra_rd", 64'(rd), 64'(exp_addr.size()));
        rd++;
      end
      if (stall) begin
        chk("stall_valid", 64'(pkt_valid), 64'd1);
        chk("stall_data", 64'(pkt_data), 64'(held));
      end
      if (done) dn++;
      chk("busy", 64'(busy), (dn == 0) ? 64'd1 : 64'd0);
      // drive
      if (v.abort_at >= 0 && idx >= v.abort_at) pkt_ready = 1'b0;
      else if (v.mode == 0) pkt_ready = 1'b1;
      else if (low > 0) begin pkt_ready = 1'b0; low--; end
      else if ($urandom_range(15) == 0) begin pkt_ready = 1'b0; low = 19; end
      else pkt_ready = 1'($urandom_range(1));
      start = 1'b0;
      if (v.start_at >= 0 && idx == v.start_at && !sdone) begin start = 1'b1; sdone = 1; end
      // handshake completes at the coming posedge
      if (pkt_valid && pkt_ready) begin
        got.push_back(pkt_data);
        if (idx < exp_pkt.size()) chk("pkt", 64'(pkt_data), 64'(exp_pkt[idx]));
        else chk("extra_pkt", 64'(idx), 64'(exp_pkt.size()));
        idx++;
      end
      stall = pkt_valid && !pkt_ready;
      held  = pkt_data;
      if (v.abort_at >= 0 && stall) begin
        sc++;
        if (sc == 3) begin
          #2 rst_n = 1'b0;
          #1;
          chk("abort_busy", 64'(busy), 64'd0);
          chk("abort_valid", 64'(pkt_valid), 64'd0);
          chk("abort_data", 64'(pkt_data), 64'd0);
          chk("abort_rd_en", 64'(mem_rd_en), 64'd0);
          chk("abort_addr", 64'(mem_addr), 64'd0);
          chk("abort_idx", 64'(idx), 64'(v.abort_at));
          fin = 1;
        end
      end
      if (dn > 0) post++;
      if (post > 3) fin = 1;
      cyc++;
      if (cyc > 5000) begin
        chk("timeout_pkts", 64'(idx), 64'(exp_pkt.size()));
        fin = 1;
      end
      if (!fin) @(negedge clk);
    end
    start = 1'b0;
    if (v.abort_at < 0) begin
      chk("pkt_count", 64'(idx), 64'(v.exp_pkts));
      chk("model_count", 64'(exp_pkt.size()), 64'(v.exp_pkts));
      chk("rd_count", 64'(rd), 64'(v.exp_rds));
      chk("done_count", 64'(dn), 64'(v.exp_done));
    end
  endtask

  typedef struct { int i; logic [7:0] xy; } diag_t;

  initial begin
    vec_t  tbl[4];
    vec_t  ab;
    diag_t dg[6];
    tbl[0] = '{0, -1, -1, 24'h0, NPKT, NRD, 1};
    tbl[1] = '{1, -1, -1, 24'h0, NPKT, NRD, 1};
    tbl[2] = '{0, 10, -1, 24'h0, NPKT, NRD, 1};
    tbl[3] = '{1, 10, -1, 24'($urandom), NPKT, NRD, 1};
    ab     = '{0, -1, 19, 24'h0, NPKT, NRD, 1};
    // ifmap k2/k3/k4 first-word destinations (ROW_WORDS=2 layout)
    dg[0] = '{24, {4'd0, 4'd3}}; dg[1] = '{25, {4'd1, 4'd2}}; dg[2] = '{26, {4'd2, 4'd1}};
    dg[3] = '{30, {4'd1, 4'd3}}; dg[4] = '{31, {4'd2, 4'd2}}; dg[5] = '{34, {4'd2, 4'd3}};

    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rd_en", 64'(mem_rd_en), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_valid", 64'(pkt_valid), 64'd0);
    chk("rst_data", 64'(pkt_data), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    for (int t = 0; t < 4; t++) begin
      run(tbl[t]);
      if (t == 0) begin
        if (got.size() >= NPKT) begin
          chk("first_pkt", 64'(got[0]), 64'({4'd0, 4'd1, 1'b0, 3'd0, 3'd0, 24'h000100}));
          chk("first_ifm", 64'(got[18]), 64'({4'd0, 4'd1, 1'b1, 3'd0, 3'd0, 24'h000110}));
          for (int j = 0; j < 6; j++) chk("diag_dst", 64'(got[dg[j].i][38:31]), 64'(dg[j].xy));
        end else chk("got_size", 64'(got.size()), 64'(NPKT));
      end
      repeat (2) @(negedge clk);
    end

    // Reset while the 20th packet is stalled, then a clean restart.
    run(ab);
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    run(tbl[0]);
    if (got.size() > 0)
      chk("restart_first", 64'(got[0]), 64'({4'd0, 4'd1, 1'b0, 3'd0, 3'd0, 24'h000100}));
    else chk("restart_size", 64'(got.size()), 64'(NPKT));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/noc_packet_injector.md
Name: noc_packet_injector

Overview:
Upstream feeder of the 3x5 mesh's injection port at router (0,0). On a start command, reads filter rows and ifmap rows from a synchronous scratchpad and packetizes them into 39-bit mesh packets for the 3x3 PE array (x=0..2, y=1..3). Filter rows go row-stationary, one per PE row. Ifmap rows go diagonally. A downstream valid/ready-to-channel bridge carries the packets into the router's local input.

Parameters:
ADDR_W, 10, scratchpad address width
ROW_WORDS, 2, 24-bit words per filter/ifmap row (1..8)
FILT_BASE, 0, scratchpad address of filter row 0
IFM_BASE, 16, scratchpad address of ifmap row 0

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begins a transfer when idle
busy  output  1  high from the cycle after accepted start until done
done  output  1  one-cycle pulse after the last packet handshake
mem_rd_en  output  1  scratchpad read strobe
mem_addr  output  ADDR_W  scratchpad read address
mem_rdata  input  24  read data, valid exactly 1 cycle after mem_rd_en
pkt_data  output  39  packet to the injection bridge
pkt_valid  output  1  packet valid
pkt_ready  input  1  bridge accepts when valid&&ready at clk edge

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, mem_rd_en, pkt_valid = 0; mem_addr, pkt_data = 0; all counters = 0.
- Packet format:
  - [38:35] dst_x; [34:31] dst_y; [30] type (0 = filter, 1 = ifmap).
  - [29:27] row index (filter r 0..2, ifmap k 0..4); [26:24] word index w; [23:0] payload = mem_rdata.
- FSM states: IDLE, F_RD, F_WAIT, F_SEND, I_RD, I_WAIT, I_SEND, DONE.
- IDLE:
  - start=1 -> F_RD; busy=1 next cycle.
  - start while busy is ignored.
- Filter phase: loop r=0..2, w=0..ROW_WORDS-1.
  - F_RD asserts mem_rd_en for one cycle, mem_addr = FILT_BASE + r*ROW_WORDS + w.
  - F_WAIT captures mem_rdata into a payload register.
  - F_SEND issues 3 packets from that one read: (x,y) = (0,r+1), (1,r+1), (2,r+1), in that order.
- Ifmap phase: loop k=0..4, w.
  - Address = IFM_BASE + k*ROW_WORDS + w.
  - Destinations: all (x, y) with x + y - 1 == k, x ascending. k0: (0,1). k1: (0,2),(1,1). k2: (0,3),(1,2),(2,1). k3: (1,3),(2,2). k4: (2,3).
- Handshake:
  - pkt_valid asserts the cycle after capture.
  - pkt_data is stable while valid && !ready.
  - On acceptance, the next destination's packet is presented the following cycle with no bubble.
  - After the last destination, go to the next read state; this gives 2 idle cycles between words.
  - pkt_valid never drops without acceptance.
- Completion:
  - After the last ifmap packet is accepted -> DONE: done=1 for one cycle, busy=0, return to IDLE.
  - Total packets = 18*ROW_WORDS.
- Reading: each word is read exactly once, with mem_rd_en high exactly one cycle per word.
- Counter wrap: w wraps to 0 and increments r/k. At filter r=2 end -> I_RD. At ifmap k=4 end -> DONE.
- pkt_ready low indefinitely: hold state, no extra reads.
- Reset mid-transfer: immediate abort; the next start restarts from filter r=0, w=0.
- Widths:
  - Address arithmetic in ADDR_W bits, wrapping modulo 2^ADDR_W.
  - ROW_WORDS > 8 is illegal (elaboration assertion).

Test Plan:
- Reset, then start with ROW_WORDS=2, pkt_ready=1, mem[a]=a+0x100 -> 36 packets.
  - First packet 39'h = {4'd0, 4'd1, 0, 3'd0, 3'd0, 24'h000100}.
  - First ifmap packet = dst (0,1), type 1, k0, w0, payload 0x110.
  - done pulses once; busy high throughout.
- Same run -> mem_rd_en pulses exactly 16 times.
  - Addresses 0..5 then 16..25, in order.
- Backpressure: pkt_ready toggled randomly, including 20-cycle lows -> pkt_data stable while stalled, identical packet sequence, no lost or duplicate packets.
- Ifmap diagonal check -> destination sequence per word:
  - k2 = (0,3),(1,2),(2,1)
  - k3 = (1,3),(2,2)
  - k4 = (2,3)
- start pulsed at packet 10 -> ignored; sequence and count unchanged.
- rst_n low during the 20th packet stall -> outputs 0 asynchronously. A new start then begins at filter r0, w0, address 0.
